// File: rtl/markup_sequencer_pkg.sv
// markup_sequencer_pkg: shared widths, tag codes, event codes and sequencer
// state encodings for the markup sequencer and its tag stack.
package markup_sequencer_pkg;

  localparam int CHAR_BITES           = 8;
  localparam int ELE_TAG_BITES        = 3;
  localparam int ATTRIBUTE_TYPE_BITES = 2;
  localparam int ATTRIBUTE_VAL_BITES  = 8;

  localparam logic [ELE_TAG_BITES-1:0] TAG_NONE = 3'd0;
  localparam logic [ELE_TAG_BITES-1:0] TAG_BODY = 3'd1;
  localparam logic [ELE_TAG_BITES-1:0] TAG_DIV  = 3'd2;
  localparam logic [ELE_TAG_BITES-1:0] TAG_P    = 3'd3;
  localparam logic [ELE_TAG_BITES-1:0] TAG_IMG  = 3'd4;
  localparam logic [ELE_TAG_BITES-1:0] TAG_SPAN = 3'd5;

  localparam logic [CHAR_BITES-1:0] CHAR_LT    = 8'h3C;
  localparam logic [CHAR_BITES-1:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    EVT_TEXT  = 2'd0,
    EVT_OPEN  = 2'd1,
    EVT_CLOSE = 2'd2,
    EVT_ATTR  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_TEXT   = 2'd0,
    ST_TAG    = 2'd1,
    ST_COMMIT = 2'd2
  } seq_state_e;

  // Void elements never occupy a stack slot.
  function automatic logic is_void_tag(input logic [ELE_TAG_BITES-1:0] tag);
    return tag == TAG_IMG;
  endfunction

endpackage

// File: rtl/markup_sequencer_tag_stack.sv
// tag_stack: fixed-depth LIFO of open element tags. Push while full and pop
// while empty are ignored; the sequencer flags those cases itself.
module tag_stack
  import markup_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ELE_TAG_BITES-1:0] din,
  output logic [ELE_TAG_BITES-1:0] top,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH_W-1:0]       count
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ELE_TAG_BITES-1:0] mem_q [STACK_DEPTH];
  logic [ELE_TAG_BITES-1:0] mem_d [STACK_DEPTH];
  logic [DEPTH_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]         wr_idx, top_idx;

  assign full    = (count_q == DEPTH_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign wr_idx  = IDX_W'(count_q);
  assign top_idx = IDX_W'(count_q - DEPTH_W'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  // Next stack contents: write at the fill level on push, shrink on pop.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      count_d       = count_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - DEPTH_W'(1);
    end
  end

  // Stack storage and fill level registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/markup_sequencer.sv
// markup_sequencer: routes text chars out as TEXT events, hands tag bodies to
// the element parser, and turns finished tags into OPEN/CLOSE/ATTR events while
// tracking nesting on a tag stack.
// Optional MARKUP_WS_COLLAPSE_EN: collapse runs of spaces into one TEXT event.
module markup_sequencer
  import markup_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [CHAR_BITES-1:0]           char_in,
  input  logic                            char_valid,
  output logic                            char_ready,
  output logic                            elem_enable,
  output logic [CHAR_BITES-1:0]           elem_char,
  input  logic                            elem_finished,
  input  logic [ELE_TAG_BITES-1:0]        elem_tag,
  input  logic                            elem_closing,
  input  logic                            elem_has_attr,
  input  logic [ATTRIBUTE_TYPE_BITES-1:0] elem_attr_type,
  input  logic [ATTRIBUTE_VAL_BITES-1:0]  elem_attr_val,
  output logic                            evt_valid,
  output logic [1:0]                      evt_type,
  output logic [CHAR_BITES-1:0]           evt_char,
  output logic [ELE_TAG_BITES-1:0]        evt_tag,
  output logic [ATTRIBUTE_TYPE_BITES-1:0] evt_attr_type,
  output logic [ATTRIBUTE_VAL_BITES-1:0]  evt_attr_val,
  output logic [DEPTH_W-1:0]              depth,
  output logic                            doc_done,
  output logic                            err_mismatch,
  output logic                            err_overflow,
  output logic                            err_underflow,
  output logic                            err_underrun
);

  seq_state_e                      state_q, state_d;
  logic                            ready_en_q, ready_en_d;
  logic                            elem_enable_q, elem_enable_d;
  logic                            has_attr_prev_q, has_attr_prev_d;
  logic                            evt_valid_q, evt_valid_d;
  evt_type_e                       evt_type_q, evt_type_d;
  logic [CHAR_BITES-1:0]           evt_char_q, evt_char_d;
  logic [ELE_TAG_BITES-1:0]        evt_tag_q, evt_tag_d;
  logic [ATTRIBUTE_TYPE_BITES-1:0] evt_attr_type_q, evt_attr_type_d;
  logic [ATTRIBUTE_VAL_BITES-1:0]  evt_attr_val_q, evt_attr_val_d;
  logic                            doc_done_q, doc_done_d;
  logic                            err_mismatch_q, err_mismatch_d;
  logic                            err_overflow_q, err_overflow_d;
  logic                            err_underflow_q, err_underflow_d;
  logic                            err_underrun_q, err_underrun_d;
`ifdef MARKUP_WS_COLLAPSE_EN
  logic                            space_run_q, space_run_d;
`endif

  logic                            char_ready_c;
  logic [CHAR_BITES-1:0]           elem_char_c;
  logic                            text_emit;
  logic                            stack_push, stack_pop;
  logic [ELE_TAG_BITES-1:0]        stack_top;
  logic                            stack_full, stack_empty;
  logic [DEPTH_W-1:0]              stack_count;

  tag_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_tag_stack (
    .clock (clock),
    .resetn(resetn),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (elem_tag),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty),
    .count (stack_count)
  );

  // Next-state, handshake and event decode for the TEXT/TAG/COMMIT sequence.
  always_comb begin
    state_d         = state_q;
    ready_en_d      = 1'b1;
    has_attr_prev_d = elem_has_attr;
    evt_valid_d     = 1'b0;
    evt_type_d      = EVT_TEXT;
    evt_char_d      = '0;
    evt_tag_d       = '0;
    evt_attr_type_d = '0;
    evt_attr_val_d  = '0;
    doc_done_d      = 1'b0;
    err_mismatch_d  = err_mismatch_q;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    err_underrun_d  = err_underrun_q;
    char_ready_c    = 1'b0;
    elem_char_c     = '0;
    text_emit       = 1'b1;
    stack_push      = 1'b0;
    stack_pop       = 1'b0;
`ifdef MARKUP_WS_COLLAPSE_EN
    space_run_d     = space_run_q;
`endif

    case (state_q)
      ST_TEXT: begin
        // ready_en_q holds char_ready low while reset is applied
        char_ready_c = ready_en_q;
        if (char_valid && ready_en_q) begin
          if (char_in == CHAR_LT) begin
            state_d = ST_TAG;
`ifdef MARKUP_WS_COLLAPSE_EN
            space_run_d = 1'b0;
`endif
          end else begin
`ifdef MARKUP_WS_COLLAPSE_EN
            text_emit   = !((char_in == CHAR_SPACE) && space_run_q);
            space_run_d = (char_in == CHAR_SPACE);
`endif
            evt_valid_d = text_emit;
            evt_type_d  = EVT_TEXT;
            evt_char_d  = text_emit ? char_in : '0;
          end
        end
      end

      ST_TAG: begin
        elem_char_c = char_in;
        if (elem_has_attr && !has_attr_prev_q) begin
          evt_valid_d     = 1'b1;
          evt_type_d      = EVT_ATTR;
          evt_attr_type_d = elem_attr_type;
          evt_attr_val_d  = elem_attr_val;
        end
        if (elem_finished) begin
          state_d = ST_COMMIT;
        end else begin
          char_ready_c = 1'b1;
          if (!char_valid) begin
            err_underrun_d = 1'b1;
            state_d        = ST_TEXT;
          end
        end
      end

      ST_COMMIT: begin
        state_d     = ST_TEXT;
        evt_valid_d = 1'b1;
        evt_tag_d   = elem_tag;
        if (!elem_closing) begin
          evt_type_d = EVT_OPEN;
          if (!is_void_tag(elem_tag)) begin
            if (stack_full) err_overflow_d = 1'b1;
            else            stack_push     = 1'b1;
          end
        end else begin
          evt_type_d = EVT_CLOSE;
          if (stack_empty) begin
            err_underflow_d = 1'b1;
          end else begin
            stack_pop = 1'b1;
            if (stack_top != elem_tag)                 err_mismatch_d = 1'b1;
            else if (stack_count == DEPTH_W'(1))       doc_done_d     = 1'b1;
          end
        end
      end

      default: state_d = ST_TEXT;
    endcase

    elem_enable_d = (state_d == ST_TAG);
  end

  // Sequencer state, registered events and sticky error flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_TEXT;
      ready_en_q      <= 1'b0;
      elem_enable_q   <= 1'b0;
      has_attr_prev_q <= 1'b0;
      evt_valid_q     <= 1'b0;
      evt_type_q      <= EVT_TEXT;
      evt_char_q      <= '0;
      evt_tag_q       <= '0;
      evt_attr_type_q <= '0;
      evt_attr_val_q  <= '0;
      doc_done_q      <= 1'b0;
      err_mismatch_q  <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_underrun_q  <= 1'b0;
`ifdef MARKUP_WS_COLLAPSE_EN
      space_run_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      ready_en_q      <= ready_en_d;
      elem_enable_q   <= elem_enable_d;
      has_attr_prev_q <= has_attr_prev_d;
      evt_valid_q     <= evt_valid_d;
      evt_type_q      <= evt_type_d;
      evt_char_q      <= evt_char_d;
      evt_tag_q       <= evt_tag_d;
      evt_attr_type_q <= evt_attr_type_d;
      evt_attr_val_q  <= evt_attr_val_d;
      doc_done_q      <= doc_done_d;
      err_mismatch_q  <= err_mismatch_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_underrun_q  <= err_underrun_d;
`ifdef MARKUP_WS_COLLAPSE_EN
      space_run_q     <= space_run_d;
`endif
    end
  end

  assign char_ready    = char_ready_c;
  assign elem_char     = elem_char_c;
  assign elem_enable   = elem_enable_q;
  assign evt_valid     = evt_valid_q;
  assign evt_type      = evt_type_q;
  assign evt_char      = evt_char_q;
  assign evt_tag       = evt_tag_q;
  assign evt_attr_type = evt_attr_type_q;
  assign evt_attr_val  = evt_attr_val_q;
  assign depth         = stack_count;
  assign doc_done      = doc_done_q;
  assign err_mismatch  = err_mismatch_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_underrun  = err_underrun_q;

endmodule

// File: tb/tb_markup_sequencer.sv
// tb_markup_sequencer: drives character documents into markup_sequencer through
// a small element-parser model and compares the event stream, depth and error
// flags against a string-level reference of the markup rules.
`timescale 1ns/1ps
module tb_markup_sequencer;
  import markup_sequencer_pkg::*;

  localparam int STACK_DEPTH = 8;
  localparam int DEPTH_W     = 4;

  logic                            clock = 1'b0;
  logic                            resetn = 1'b0;
  logic [CHAR_BITES-1:0]           char_in = '0;
  logic                            char_valid = 1'b0;
  logic                            char_ready;
  logic                            elem_enable;
  logic [CHAR_BITES-1:0]           elem_char;
  logic                            elem_finished;
  logic [ELE_TAG_BITES-1:0]        elem_tag;
  logic                            elem_closing;
  logic                            elem_has_attr;
  logic [ATTRIBUTE_TYPE_BITES-1:0] elem_attr_type;
  logic [ATTRIBUTE_VAL_BITES-1:0]  elem_attr_val;
  logic                            evt_valid;
  logic [1:0]                      evt_type;
  logic [CHAR_BITES-1:0]           evt_char;
  logic [ELE_TAG_BITES-1:0]        evt_tag;
  logic [ATTRIBUTE_TYPE_BITES-1:0] evt_attr_type;
  logic [ATTRIBUTE_VAL_BITES-1:0]  evt_attr_val;
  logic [DEPTH_W-1:0]              depth;
  logic                            doc_done;
  logic                            err_mismatch, err_overflow, err_underflow, err_underrun;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  markup_sequencer #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clock(clock), .resetn(resetn),
    .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .elem_enable(elem_enable), .elem_char(elem_char),
    .elem_finished(elem_finished), .elem_tag(elem_tag), .elem_closing(elem_closing),
    .elem_has_attr(elem_has_attr), .elem_attr_type(elem_attr_type), .elem_attr_val(elem_attr_val),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_char(evt_char), .evt_tag(evt_tag),
    .evt_attr_type(evt_attr_type), .evt_attr_val(evt_attr_val),
    .depth(depth), .doc_done(doc_done),
    .err_mismatch(err_mismatch), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_underrun(err_underrun)
  );

  function automatic logic [ELE_TAG_BITES-1:0] tag_code(input byte c);
    case (c)
      "b":     return TAG_BODY;
      "d":     return TAG_DIV;
      "p":     return TAG_P;
      "i":     return TAG_IMG;
      "s":     return TAG_SPAN;
      default: return TAG_NONE;
    endcase
  endfunction

  function automatic logic [ATTRIBUTE_TYPE_BITES-1:0] attr_code(input byte c);
    case (c)
      "s":     return 2'd1;
      "c":     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Element parser model: consumes one char per clock while enabled, cleared when disabled.
  logic                            p_fin, p_close, p_seen, p_sp, p_eq, p_attr;
  logic [ELE_TAG_BITES-1:0]        p_tag;
  logic [ATTRIBUTE_TYPE_BITES-1:0] p_atype;
  logic [ATTRIBUTE_VAL_BITES-1:0]  p_aval;

  always @(posedge clock or negedge resetn) begin
    if (!resetn || !elem_enable) begin
      p_fin <= 1'b0; p_close <= 1'b0; p_seen <= 1'b0; p_sp <= 1'b0;
      p_eq <= 1'b0; p_attr <= 1'b0; p_tag <= '0; p_atype <= '0; p_aval <= '0;
    end else if (!p_fin && elem_char != 8'h00) begin
      if (elem_char == "/" && !p_seen) p_close <= 1'b1;
      else if (elem_char == ">") p_fin <= 1'b1;
      else if (p_eq) begin
        if (!p_attr) begin p_attr <= 1'b1; p_aval <= elem_char; end
        p_eq <= 1'b0;
      end
      else if (elem_char == "=") p_eq <= 1'b1;
      else if (elem_char == " ") p_sp <= 1'b1;
      else if (!p_seen) begin p_tag <= tag_code(elem_char); p_seen <= 1'b1; end
      else if (p_sp) begin p_atype <= attr_code(elem_char); p_sp <= 1'b0; end
    end
  end

  assign elem_finished  = p_fin;
  assign elem_tag       = p_tag;
  assign elem_closing   = p_close;
  assign elem_has_attr  = p_attr;
  assign elem_attr_type = p_atype;
  assign elem_attr_val  = p_aval;

  typedef struct packed {
    logic [1:0] t;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] dep;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  int  done_cnt;
  int  exp_depth, exp_done;
  bit  exp_mis, exp_ovf, exp_und;

  // Event monitor samples on the falling edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (evt_valid) begin
        mon_e   = '0;
        mon_e.t = evt_type;
        case (evt_type)
          2'd0:    mon_e.d = evt_char;
          2'd3:    begin mon_e.a = 8'(evt_attr_type); mon_e.d = evt_attr_val; end
          default: begin mon_e.d = 8'(evt_tag); mon_e.dep = 8'(depth); end
        endcase
        obs_q.push_back(mon_e);
      end
      if (doc_done) done_cnt++;
    end
  end

  // Reference: walk the document string and apply the markup rules directly.
  task automatic model(input string s);
    int  stk[$];
    bit  run, cl, ha;
    int  i, j;
    byte c;
    logic [ELE_TAG_BITES-1:0] tg;
    logic [7:0] av;
    logic [ATTRIBUTE_TYPE_BITES-1:0] at;
    ev_t e;
    exp_q.delete();
    exp_mis = 0; exp_ovf = 0; exp_und = 0; exp_done = 0;
    run = 0; i = 0; at = '0; av = '0;
    while (i < s.len()) begin
      c = s[i];
      if (c == "<") begin
        run = 0; j = i + 1; cl = 0; ha = 0;
        if (s[j] == "/") begin cl = 1; j++; end
        tg = tag_code(s[j]); j++;
        while (s[j] != ">") begin
          if (s[j] == "=") begin ha = 1; av = s[j+1]; j += 2; end
          else if (s[j] == " ") begin at = attr_code(s[j+1]); j += 2; end
          else j++;
        end
        i = j + 1;
        if (ha) begin e = '0; e.t = 2'd3; e.a = 8'(at); e.d = av; exp_q.push_back(e); end
        if (!cl) begin
          if (tg != TAG_IMG) begin
            if (stk.size() == STACK_DEPTH) exp_ovf = 1;
            else stk.push_back(int'(tg));
          end
          e = '0; e.t = 2'd1;
        end else begin
          if (stk.size() == 0) exp_und = 1;
          else begin
            if (stk[$] != int'(tg)) exp_mis = 1;
            else if (stk.size() == 1) exp_done++;
            void'(stk.pop_back());
          end
          e = '0; e.t = 2'd2;
        end
        e.d = 8'(tg); e.dep = 8'(stk.size());
        exp_q.push_back(e);
      end else begin
`ifdef MARKUP_WS_COLLAPSE_EN
        if (!(c == " " && run)) begin e = '0; e.d = c; exp_q.push_back(e); end
        run = (c == " ");
`else
        e = '0; e.d = c; exp_q.push_back(e);
`endif
        i++;
      end
    end
    exp_depth = stk.size();
  endtask

  task automatic apply_reset();
    char_valid = 1'b0; char_in = '0; resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_char(input byte c);
    bit got;
    char_in = c; char_valid = 1'b1; got = 0;
    for (int w = 0; w < 20; w++) begin
      if (char_ready) begin got = 1; @(negedge clock); break; end
      @(negedge clock);
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout char=%c got char_ready=0 want 1 within 20 cycles", c);
    end
  endtask

  task automatic run_doc(input string s, input bit gaps);
    bit  in_tag;
    byte c;
    apply_reset();
    obs_q.delete(); done_cnt = 0;
    model(s);
    in_tag = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (gaps && !in_tag && $urandom_range(0, 3) == 0) begin
        char_valid = 1'b0; char_in = '0; @(negedge clock);
      end
      send_char(c);
      if (c == "<") in_tag = 1;
      else if (c == ">") in_tag = 0;
    end
    char_valid = 1'b0; char_in = '0;
    repeat (8) @(negedge clock);
  endtask

  function automatic string gen_doc();
    string s, tx, op, cl;
    byte   st[$];
    byte   ch;
    int    n;
    s = ""; tx = "ab xy  "; op = "bdpsi"; cl = "bdps";
    n = $urandom_range(6, 16);
    for (int k = 0; k < n; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) begin
        s = $sformatf("%s%c", s, tx[$urandom_range(0, tx.len() - 1)]);
      end else if (r < 8) begin
        ch = op[$urandom_range(0, op.len() - 1)];
        if (ch == "i" || $urandom_range(0, 2) == 0)
          s = $sformatf("%s<%c %c=%c>", s, ch, ($urandom_range(0, 1) != 0) ? "s" : "c",
                        8'($urandom_range(97, 122)));
        else
          s = $sformatf("%s<%c>", s, ch);
        if (ch != "i") st.push_back(ch);
      end else begin
        if (st.size() != 0 && $urandom_range(0, 3) != 0) ch = st.pop_back();
        else ch = cl[$urandom_range(0, cl.len() - 1)];
        s = $sformatf("%s</%c>", s, ch);
      end
    end
    return s;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; char_valid = 1'b0; char_in = '0;
    #1;
    checks++;
    if ({char_ready, elem_enable, elem_char, evt_valid, evt_type, evt_char, evt_tag, evt_attr_type,
         evt_attr_val, depth, doc_done, err_mismatch, err_overflow, err_underflow, err_underrun} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got ready=%b en=%b evt=%b depth=%0d errs=%b%b%b%b want all 0",
               char_ready, elem_enable, evt_valid, depth, err_mismatch, err_overflow, err_underflow, err_underrun);
    end
    run_doc("</d>", 0);
    send_char("<");
    send_char("d");
    checks++;
    if (elem_enable !== 1'b1 || err_underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_state got en=%b underflow=%b want en=1 underflow=1", elem_enable, err_underflow);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({char_ready, elem_enable, elem_char, evt_valid, evt_type, depth, doc_done,
         err_mismatch, err_overflow, err_underflow, err_underrun} !== '0) begin
      errors++;
      $display("[TB] FAIL midtag_reset got ready=%b en=%b evt=%b depth=%0d errs=%b%b%b%b want all 0",
               char_ready, elem_enable, evt_valid, depth, err_mismatch, err_overflow, err_underflow, err_underrun);
    end
    char_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  string docs [7] = '{"ab<d>", "<b><p>x</p></b>", "<d></p>", "</d>",
                      "<d><d><d><d><d><d><d><d><d>", "<d><i s=v>", "a   b"};

  task automatic test_documents();
    foreach (docs[n]) begin
      run_doc(docs[n], 0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL evt_count doc=%s got %0d want %0d", docs[n], obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k < obs_q.size()) begin
          checks++;
          if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("[TB] FAIL event doc=%s idx=%0d got t=%0d a=%0h d=%0h dep=%0d want t=%0d a=%0h d=%0h dep=%0d",
                     docs[n], k, obs_q[k].t, obs_q[k].a, obs_q[k].d, obs_q[k].dep,
                     exp_q[k].t, exp_q[k].a, exp_q[k].d, exp_q[k].dep);
          end
        end
      end
      checks++;
      if (depth !== DEPTH_W'(exp_depth)) begin
        errors++;
        $display("[TB] FAIL depth doc=%s got %0d want %0d", docs[n], depth, exp_depth);
      end
      checks++;
      if ({err_mismatch, err_overflow, err_underflow, err_underrun} !== {exp_mis, exp_ovf, exp_und, 1'b0}) begin
        errors++;
        $display("[TB] FAIL errors doc=%s got mis/ovf/und/urun=%b%b%b%b want %b%b%b0", docs[n],
                 err_mismatch, err_overflow, err_underflow, err_underrun, exp_mis, exp_ovf, exp_und);
      end
      checks++;
      if (done_cnt != exp_done) begin
        errors++;
        $display("[TB] FAIL doc_done doc=%s got %0d pulses want %0d", docs[n], done_cnt, exp_done);
      end
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    obs_q.delete(); done_cnt = 0;
    send_char("<");
    send_char("d");
    char_valid = 1'b0; char_in = '0;
    @(negedge clock);
    checks++;
    if (elem_enable !== 1'b0 || err_underrun !== 1'b1 || depth !== '0) begin
      errors++;
      $display("[TB] FAIL underrun got en=%b underrun=%b depth=%0d want en=0 underrun=1 depth=0",
               elem_enable, err_underrun, depth);
    end
    send_char("z");
    char_valid = 1'b0; char_in = '0;
    repeat (4) @(negedge clock);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL underrun_evt_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].t !== 2'd0 || obs_q[0].d !== "z") begin
        errors++;
        $display("[TB] FAIL underrun_text got t=%0d d=%0h want t=0 d=7a", obs_q[0].t, obs_q[0].d);
      end
    end
  endtask

  task automatic test_random();
    string s;
    for (int n = 0; n < 20; n++) begin
      s = gen_doc();
      run_doc(s, 1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL rand_evt_count doc=%s got %0d want %0d", s, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k < obs_q.size()) begin
          checks++;
          if (obs_q[k] !== exp_q[k]) begin
            errors++;
            $display("[TB] FAIL rand_event doc=%s idx=%0d got t=%0d a=%0h d=%0h dep=%0d want t=%0d a=%0h d=%0h dep=%0d",
                     s, k, obs_q[k].t, obs_q[k].a, obs_q[k].d, obs_q[k].dep,
                     exp_q[k].t, exp_q[k].a, exp_q[k].d, exp_q[k].dep);
          end
        end
      end
      checks++;
      if (depth !== DEPTH_W'(exp_depth)) begin
        errors++;
        $display("[TB] FAIL rand_depth doc=%s got %0d want %0d", s, depth, exp_depth);
      end
      checks++;
      if ({err_mismatch, err_overflow, err_underflow, err_underrun} !== {exp_mis, exp_ovf, exp_und, 1'b0}) begin
        errors++;
        $display("[TB] FAIL rand_errors doc=%s got %b%b%b%b want %b%b%b0", s,
                 err_mismatch, err_overflow, err_underflow, err_underrun, exp_mis, exp_ovf, exp_und);
      end
      checks++;
      if (done_cnt != exp_done) begin
        errors++;
        $display("[TB] FAIL rand_doc_done doc=%s got %0d want %0d", s, done_cnt, exp_done);
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_documents();
    test_underrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
